// File: rtl/esm_pkg.sv
// Shared definitions for the ESM front end: the opcodes it understands, the
// issue-queue entry layout and the all-zero bubble.
package esm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CSTORE = 7'b1010011;

    typedef struct packed {
        logic [31:0] instr;
        logic        alusrc;
        logic        regwrite;
    } iq_entry_t;

    localparam iq_entry_t BUBBLE = '{instr: 32'h0000_0000, alusrc: 1'b0, regwrite: 1'b0};

    // Builds a queue entry from a word and its decoded control bits.
    function automatic iq_entry_t make_entry(input logic [31:0] instr,
                                             input logic        alusrc,
                                             input logic        regwrite);
        iq_entry_t e;
        e.instr    = instr;
        e.alusrc   = alusrc;
        e.regwrite = regwrite;
        return e;
    endfunction

endpackage

// File: rtl/instr_ctrl_decode.sv
// Combinational opcode decoder: classifies an RV32 word as legal and derives
// ALUSrc / RegWrite. Shared by other front-end blocks.
module instr_ctrl_decode
    import esm_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal,
    output logic        alusrc,
    output logic        regwrite
);

    // Opcode lookup; anything unlisted is illegal and carries no control bits.
    always_comb begin
        legal    = 1'b0;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        case (instr[6:0])
            OP_R: begin
                legal    = 1'b1;
                alusrc   = 1'b0;
                regwrite = 1'b1;
            end
            OP_I: begin
                legal    = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_LOAD: begin
                legal    = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_STORE: begin
                legal    = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b0;
            end
            OP_CSTORE: begin
                legal    = 1'b1;
                alusrc   = 1'b0;
                regwrite = 1'b0;
            end
            default: begin
                legal    = 1'b0;
                alusrc   = 1'b0;
                regwrite = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue feeding ESM: decodes at push, issues one entry per
// cycle or a zero bubble. Optional sticky illegal-opcode trap: ILLEGAL_TRAP_EN.
module instr_issue_queue
    import esm_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        issue_en,
    input  logic        flush,
    output logic [31:0] Instr_out,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [AW:0] count,
    output logic        illegal
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    iq_entry_t     mem_r [DEPTH];
    iq_entry_t     out_r;
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_nxt_s;
    logic          in_ready_r;
    logic          legal_s;
    logic          dec_alusrc_s;
    logic          dec_regwrite_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    instr_ctrl_decode u_decode (
        .instr    (in_instr),
        .legal    (legal_s),
        .alusrc   (dec_alusrc_s),
        .regwrite (dec_regwrite_s)
    );

    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign empty_s = (count_r == {(AW+1){1'b0}});
    assign push_s  = in_valid & in_ready_r & legal_s & ~flush;
    assign pop_s   = issue_en & ~empty_s & ~flush;

    // Next occupancy, also used to precompute the registered in_ready.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = {(AW+1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + (AW+1)'(1);
                2'b01:   count_nxt_s = count_r - (AW+1)'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            in_ready_r <= 1'b1;
        end else if (flush) begin
            wptr_r     <= {AW{1'b0}};
            rptr_r     <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != FULL_CNT);
        end
    end

    // Entry storage; contents are only meaningful between rptr and wptr.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= make_entry(in_instr, dec_alusrc_s, dec_regwrite_s);
        end
    end

    // Issue register: head entry on a pop, otherwise a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r <= BUBBLE;
        end else if (pop_s) begin
            out_r <= mem_r[rptr_r];
        end else begin
            out_r <= BUBBLE;
        end
    end

    assign Instr_out = out_r.instr;
    assign ALUSrc    = out_r.alusrc;
    assign RegWrite  = out_r.regwrite;
    assign count     = count_r;
    assign in_ready  = in_ready_r;

`ifdef ILLEGAL_TRAP_EN
    logic       illegal_r;
    logic [7:0] illegal_cnt;
    logic       drop_s;

    assign drop_s = in_valid & ~legal_s;

    // Sticky trap and saturating drop counter; only reset clears them, not flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_r   <= 1'b0;
            illegal_cnt <= 8'h00;
        end else if (drop_s) begin
            illegal_r <= 1'b1;
            if (illegal_cnt != 8'hFF) begin
                illegal_cnt <= illegal_cnt + 8'h01;
            end else begin
                illegal_cnt <= illegal_cnt;
            end
        end else begin
            illegal_r   <= illegal_r;
            illegal_cnt <= illegal_cnt;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

endmodule
